// File: rtl/vga_timing_decoder.sv
// Recovers pixel coordinates, frame geometry and lock status from an active-low vs/hs/blank stream.
// Optional DEC_NOMINAL_CHECK_EN: lock additionally requires H_TOTAL_NOM x V_TOTAL_NOM geometry.
module vga_timing_decoder #(
  parameter int CNT_W       = 13,
  parameter int LOCK_FRAMES = 2,
  parameter int H_TOTAL_NOM = 800,
  parameter int V_TOTAL_NOM = 525
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vs_ni,
  input  logic             hs_ni,
  input  logic             blank_ni,
  output logic [CNT_W-1:0] col_o,
  output logic [CNT_W-1:0] row_o,
  output logic             active_o,
  output logic             sof_o,
  output logic             eol_o,
  output logic [CNT_W-1:0] h_total_o,
  output logic [CNT_W-1:0] v_total_o,
  output logic [CNT_W-1:0] h_active_o,
  output logic [CNT_W-1:0] v_active_o,
  output logic             locked_o,
  output logic             err_o
);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} lock_state_e;

`ifdef DEC_NOMINAL_CHECK_EN
  localparam bit NOM_CHECK = 1'b1;
`else
  localparam bit NOM_CHECK = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic vs1_q, vs1_d, hs1_q, hs1_d, blank1_q, blank1_d;
  logic vs2_q, vs2_d, hs2_q, hs2_d, blank2_q, blank2_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d, act_lines_q, act_lines_d;
  logic [CNT_W-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
  logic [CNT_W-1:0] h_active_q, h_active_d, v_active_q, v_active_d;
  logic active_q, active_d, sof_q, sof_d, eol_q, eol_d;
  logic locked_q, locked_d, err_q, err_d;
  lock_state_e state_q, state_d;
  logic [7:0] good_q, good_d;
  logic line_bad_q, line_bad_d, first_frame_q, first_frame_d;

  logic hs_fall, vs_fall, blank_rise, blank_fall;
  logic h_sat, h_bad, v_bad, nom_ok, line_bad_now, frame_ok;
  logic [CNT_W-1:0] h_cnt_inc, act_lines_inc;
  logic [7:0] good_inc;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    vs1_d    = vs_ni;
    hs1_d    = hs_ni;
    blank1_d = blank_ni;
    vs2_d    = vs1_q;
    hs2_d    = hs1_q;
    blank2_d = blank1_q;

    hs_fall    = hs2_q & ~hs1_q;
    vs_fall    = vs2_q & ~vs1_q;
    blank_rise = blank1_q & ~blank2_q;
    blank_fall = ~blank1_q & blank2_q;

    h_cnt_inc     = h_cnt_q + ONE;
    act_lines_inc = act_lines_q + ONE;
    h_sat  = !hs_fall && (h_cnt_q == CNT_MAX - ONE);
    h_bad  = hs_fall && (h_cnt_inc != h_total_q);
    v_bad  = (v_cnt_q != v_total_q);
    nom_ok = !NOM_CHECK || ((h_total_q == CNT_W'(H_TOTAL_NOM)) &&
                            (v_cnt_q == CNT_W'(V_TOTAL_NOM)));

    // Line and frame measurement, independent of lock state
    h_cnt_d   = hs_fall ? '0 : ((h_cnt_q == CNT_MAX) ? CNT_MAX : h_cnt_inc);
    h_total_d = hs_fall ? h_cnt_inc : h_total_q;
    v_cnt_d   = hs_fall ? v_cnt_q + ONE : v_cnt_q;
    v_total_d = v_total_q;
    if (vs_fall) begin
      v_total_d = v_cnt_q;
      v_cnt_d   = hs_fall ? ONE : '0;
    end

    col_d       = col_q;
    row_d       = row_q;
    act_lines_d = act_lines_q;
    h_active_d  = h_active_q;
    v_active_d  = v_active_q;
    if (blank_rise) begin
      col_d = '0;
    end else if (blank1_q) begin
      col_d = col_q + ONE;
    end
    if (blank_fall) begin
      h_active_d  = col_q + ONE;
      row_d       = row_q + ONE;
      act_lines_d = act_lines_inc;
    end
    if (vs_fall) begin
      v_active_d  = blank_fall ? act_lines_inc : act_lines_q;
      row_d       = '0;
      act_lines_d = '0;
    end

    active_d = blank1_q;
    sof_d    = blank_rise && (row_q == '0) && (act_lines_q == '0);
    // The pin is what stage 1 holds next cycle, so this flags the final active pixel
    eol_d    = blank1_q && !blank_ni;

    state_d       = state_q;
    good_d        = good_q;
    line_bad_d    = line_bad_q;
    first_frame_d = first_frame_q;
    err_d         = 1'b0;
    line_bad_now  = line_bad_q | h_bad;
    frame_ok      = 1'b0;
    good_inc      = good_q + 8'd1;
    unique case (state_q)
      UNLOCKED: begin
        if (vs_fall) begin
          state_d       = ACQUIRE;
          good_d        = '0;
          line_bad_d    = 1'b0;
          first_frame_d = 1'b1;
        end
      end
      ACQUIRE: begin
        if (h_sat) begin
          state_d = UNLOCKED;
        end else if (vs_fall) begin
          // v_total_o captured while unlocked may come from a partial frame; skip it as reference
          frame_ok      = !line_bad_now && (first_frame_q || !v_bad) && nom_ok;
          good_d        = frame_ok ? good_inc : '0;
          line_bad_d    = 1'b0;
          first_frame_d = 1'b0;
          if (frame_ok && (good_inc >= 8'(LOCK_FRAMES))) state_d = LOCKED;
        end else begin
          line_bad_d = line_bad_now;
        end
      end
      LOCKED: begin
        if (h_bad || h_sat || (vs_fall && (v_bad || !nom_ok))) begin
          err_d   = 1'b1;
          state_d = UNLOCKED;
        end
      end
      default: state_d = UNLOCKED;
    endcase
    locked_d = (state_d == LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      {vs1_q, hs1_q, blank1_q, vs2_q, hs2_q, blank2_q} <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      col_q         <= '0;
      row_q         <= '0;
      act_lines_q   <= '0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      h_active_q    <= '0;
      v_active_q    <= '0;
      active_q      <= 1'b0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      state_q       <= UNLOCKED;
      good_q        <= '0;
      line_bad_q    <= 1'b0;
      first_frame_q <= 1'b0;
    end else begin
      {vs1_q, hs1_q, blank1_q} <= {vs1_d, hs1_d, blank1_d};
      {vs2_q, hs2_q, blank2_q} <= {vs2_d, hs2_d, blank2_d};
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      act_lines_q   <= act_lines_d;
      h_total_q     <= h_total_d;
      v_total_q     <= v_total_d;
      h_active_q    <= h_active_d;
      v_active_q    <= v_active_d;
      active_q      <= active_d;
      sof_q         <= sof_d;
      eol_q         <= eol_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
      state_q       <= state_d;
      good_q        <= good_d;
      line_bad_q    <= line_bad_d;
      first_frame_q <= first_frame_d;
    end
  end

  assign col_o      = col_q;
  assign row_o      = row_q;
  assign active_o   = active_q;
  assign sof_o      = sof_q;
  assign eol_o      = eol_q;
  assign h_total_o  = h_total_q;
  assign v_total_o  = v_total_q;
  assign h_active_o = h_active_q;
  assign v_active_o = v_active_q;
  assign locked_o   = locked_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Bench for vga_timing_decoder on a scaled 40x20 raster (hs low x=2..5, vs low y=2..3,
// active x>=8 && y>=5); pixel outputs are checked through a 2-deep latency scoreboard.
module tb_vga_timing_decoder;
  localparam int CNT_W = 13;
  localparam int H_TOT = 40;
  localparam int V_TOT = 20;
  localparam int X_ACT = 8;
  localparam int Y_ACT = 5;

  logic clk = 1'b0;
  logic rst, vs_ni, hs_ni, blank_ni;
  logic [CNT_W-1:0] col_o, row_o, h_total_o, v_total_o, h_active_o, v_active_o;
  logic active_o, sof_o, eol_o, locked_o, err_o;

  vga_timing_decoder #(
    .CNT_W(CNT_W), .LOCK_FRAMES(2), .H_TOTAL_NOM(H_TOT), .V_TOTAL_NOM(V_TOT)
  ) dut (
    .clk(clk), .rst(rst), .vs_ni(vs_ni), .hs_ni(hs_ni), .blank_ni(blank_ni),
    .col_o(col_o), .row_o(row_o), .active_o(active_o), .sof_o(sof_o), .eol_o(eol_o),
    .h_total_o(h_total_o), .v_total_o(v_total_o), .h_active_o(h_active_o),
    .v_active_o(v_active_o), .locked_o(locked_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               chk;
    logic             act, sof, eol;
    logic [CNT_W-1:0] col, row;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int sof_cnt = 0;
  int eol_cnt = 0;
  int base_err, base_sof, base_eol;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel clock: drive the raster at (x,y) and queue what the outputs must show 2 clocks later
  task automatic step(input int x, input int y, input int ll, input bit chk, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    vs_ni    = !(y == 2 || y == 3);
    hs_ni    = !(x >= 2 && x <= 5);
    blank_ni = (x >= X_ACT) && (y >= Y_ACT);
    e.chk = chk;
    e.act = blank_ni;
    e.sof = (x == X_ACT) && (y == Y_ACT);
    e.eol = blank_ni && (x == ll - 1);
    e.col = CNT_W'(x - X_ACT);
    e.row = CNT_W'(y - Y_ACT);
    sbq.push_back(e);
  endtask

  task automatic frame(input int h_len, input bit chk, input int long_y);
    for (int y = 0; y < V_TOT; y++) begin
      int ll;
      ll = (y == long_y) ? h_len + 1 : h_len;
      for (int x = 0; x < ll; x++) step(x, y, ll, chk, 1'b0);
    end
  endtask

  task automatic frame_with_reset();
    for (int y = 0; y < V_TOT; y++) begin
      for (int x = 0; x < H_TOT; x++) begin
        step(x, y, H_TOT, 1'b0, (x == 20) && (y == 10));
        if (x == 21 && y == 10) begin
          @(negedge clk);
          check("midrst_locked", locked_o, 0);
          check("midrst_active", active_o, 0);
          check("midrst_col", col_o, 0);
          check("midrst_row", row_o, 0);
          check("midrst_h_total", h_total_o, 0);
          check("midrst_v_active", v_active_o, 0);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (err_o === 1'b1) err_cnt++;
    if (sof_o === 1'b1) sof_cnt++;
    if (eol_o === 1'b1) eol_cnt++;
    if (sbq.size() == 3) begin
      mon_e = sbq.pop_front();
      if (mon_e.chk) begin
        check("px_active", active_o, mon_e.act);
        check("px_sof", sof_o, mon_e.sof);
        check("px_eol", eol_o, mon_e.eol);
        check("px_locked", locked_o, 1);
        check("px_err", err_o, 0);
        if (mon_e.act) begin
          check("px_col", col_o, mon_e.col);
          check("px_row", row_o, mon_e.row);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; vs_ni = 1'b1; hs_ni = 1'b1; blank_ni = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_locked", locked_o, 0);
    check("rst_err", err_o, 0);
    check("rst_active", active_o, 0);
    check("rst_h_total", h_total_o, 0);
    check("rst_v_total", v_total_o, 0);

    // Nominal frames: lock appears with the third vs fall
    base_err = err_cnt;
    frame(H_TOT, 1'b0, -1);
    frame(H_TOT, 1'b0, -1);
    check("lock_before_3rd_vs", locked_o, 0);
    frame(H_TOT, 1'b0, -1);
    check("lock_after_3rd_vs", locked_o, 1);
    frame(H_TOT, 1'b1, -1);
    check("h_total", h_total_o, H_TOT);
    check("v_total", v_total_o, V_TOT);
    check("h_active", h_active_o, H_TOT - X_ACT);
    check("v_active", v_active_o, V_TOT - Y_ACT);
    check("no_err_nominal", err_cnt - base_err, 0);

    // Locked frame scan: one sof and one eol per active line
    base_sof = sof_cnt;
    base_eol = eol_cnt;
    frame(H_TOT, 1'b1, -1);
    check("sof_per_frame", sof_cnt - base_sof, 1);
    check("eol_per_frame", eol_cnt - base_eol, V_TOT - Y_ACT);

    // One over-long line drops lock with a single err pulse, relock three vs falls later
    base_err = err_cnt;
    frame(H_TOT, 1'b0, 10);
    check("long_line_err", err_cnt - base_err, 1);
    check("long_line_unlocked", locked_o, 0);
    frame(H_TOT, 1'b0, -1);
    frame(H_TOT, 1'b0, -1);
    check("long_line_relock_early", locked_o, 0);
    frame(H_TOT, 1'b0, -1);
    check("long_line_relock", locked_o, 1);
    check("long_line_err_once", err_cnt - base_err, 1);

    // hs held high until the line counter saturates
    base_err = err_cnt;
    for (int i = 0; i < 8300; i++) step(20, 0, H_TOT, 1'b0, 1'b0);
    check("sat_err", err_cnt - base_err, 1);
    check("sat_unlocked", locked_o, 0);
    for (int f = 0; f < 3; f++) frame(H_TOT, 1'b0, -1);
    check("sat_relock", locked_o, 1);
    check("sat_h_total", h_total_o, H_TOT);

    // Reset mid-frame: full restart, lock back after three vs falls
    base_err = err_cnt;
    frame_with_reset();
    frame(H_TOT, 1'b0, -1);
    frame(H_TOT, 1'b0, -1);
    check("rst_relock_early", locked_o, 0);
    frame(H_TOT, 1'b0, -1);
    check("rst_relock", locked_o, 1);
    check("rst_no_err", err_cnt - base_err, 0);
    frame(H_TOT, 1'b1, -1);

    // Short lines: geometry-agnostic build locks on them, nominal build does not
    for (int f = 0; f < 4; f++) frame(H_TOT - 5, 1'b0, -1);
    check("short_h_total", h_total_o, H_TOT - 5);
    check("short_h_active", h_active_o, H_TOT - 5 - X_ACT);
    check("short_v_total", v_total_o, V_TOT);
`ifdef DEC_NOMINAL_CHECK_EN
    check("short_locked", locked_o, 0);
`else
    check("short_locked", locked_o, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
